// File: rtl/seg_pkg.sv
// Shared constants, phase type and hex-to-segment decode for the 7-segment scan driver.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic {
        BLANK,
        SHOW
    } seg_phase_t;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_mux_drv.sv
// Four-digit 7-segment scan driver with per-slot dead-time blanking,
// frame-coherent value shadowing and optional leading-zero suppression.
module seg_mux_drv
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned DIGIT_HZ  = 1000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned DIV = CLK_HZ / DIGIT_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    if (!(BLANK_CYC > 0 && BLANK_CYC < DIV)) begin : g_bad_blank
        $error("seg_mux_drv: BLANK_CYC must satisfy 0 < BLANK_CYC < CLK_HZ/DIGIT_HZ");
    end

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [3:0]    dp_in_sh;

    seg_phase_t    phase;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic [3:0]    lz_mask;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          fd_nxt;

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        nibble = shadow[4*idx +: 4];
        phase  = (cnt < BLANK_END) ? BLANK : SHOW;

        // A digit is a leading zero when it and every nibble above it are zero.
        lz_mask    = '0;
        lz_mask[3] = (shadow[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (shadow[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (shadow[7:4] == 4'h0);

        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        fd_nxt  = (idx == 2'd3) && (cnt == CNT_MAX);

        case (phase)
            SHOW: begin
                an_nxt  = ~(4'b0001 << idx);
                seg_nxt = (lz_en && lz_mask[idx]) ? SEG_OFF : dec_seg;
                dp_nxt  = ~dp_in_sh[idx];
            end
            default: begin
                an_nxt  = AN_OFF;
                seg_nxt = SEG_OFF;
                dp_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            dp_in_sh   <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (idx == 2'd0 && cnt == '0) begin
                shadow   <= value;
                dp_in_sh <= dp_in;
            end
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_mux_drv.sv
// Self-checking bench for seg_mux_drv against a frame-position reference model.
module tb_seg_mux_drv;

    localparam int unsigned DIVT  = 10;
    localparam int unsigned BLKT  = 2;
    localparam int unsigned FRAME = 4 * DIVT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h1A8F;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_mux_drv #(
        .CLK_HZ    (1000),
        .DIGIT_HZ  (100),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: position in frame derives from edges since reset release.
    int unsigned edges = 0;
    logic [15:0] fr_val = '0;
    logic [3:0]  fr_dp  = '0;
    logic [3:0]  prev_an = 4'hF;
    int unsigned blank_run = 0;

    always @(posedge clk) begin
        logic        r, lz;
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        int unsigned k, f, dig, c;
        int          hi;
        r = rst; v = value; d = dp_in; lz = lz_en;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (r) begin
            edges  = 0;
            fr_val = '0;
            fr_dp  = '0;
        end else begin
            k = edges;
            edges++;
            f   = k % FRAME;
            dig = f / DIVT;
            c   = f % DIVT;
            if (f == 0) begin
                fr_val = v;
                fr_dp  = d;
            end
            if (c >= BLKT) begin
                hi = -1;
                for (int i = 0; i < 4; i++)
                    if (((fr_val >> (4 * i)) & 16'hF) != 0) hi = i;
                e_an  = ~(4'b0001 << dig);
                e_seg = seg_tbl[(fr_val >> (4 * dig)) & 16'hF];
                if (lz && dig > 0 && int'(dig) > hi) e_seg = 7'h7F;
                e_dp  = ~fr_dp[dig];
            end
            e_fd = (f == FRAME - 1);
        end
        #1;
        chk("an", {12'h0, an}, {12'h0, e_an});
        chk("seg", {9'h0, seg}, {9'h0, e_seg});
        chk("dp", {15'h0, dp}, {15'h0, e_dp});
        chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
        if (an != 4'hF)
            chk("an_onehot", 16'($countones(~an)), 16'd1);
        if (an != prev_an && an != 4'hF)
            chk("blank_gap", {15'h0, (prev_an == 4'hF && blank_run >= 2)}, 16'd1);
        blank_run = (an == 4'hF) ? blank_run + 1 : 0;
        prev_an   = an;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 0) r[4*i +: 4] = 4'h0;
        return r;
    endfunction

    initial begin
        cycles(3);
        rst = 1'b0;
        // value change lands before edge 15, mid-frame
        cycles(14);
        value = 16'h0000;
        cycles(70);
        lz_en = 1'b1;
        value = 16'h0010;
        cycles(90);
        dp_in = 4'b0100;
        cycles(90);
        lz_en = 1'b0;
        value = 16'h1A8F;
        dp_in = 4'b0000;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(16);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(60);
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 14) == 0) value = rand_val();
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            else rst = 1'b0;
            cycles(1);
        end
        rst = 1'b0;
        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_drv.md
# seg_mux_drv

Cathode-side driver for the Basys3 four-digit 7-segment display. It time-multiplexes a 16-bit hex value across the four digits and generates matching active-low anode selects and segment/decimal-point patterns. It inserts a dead-time blanking interval before each digit switch to suppress ghosting, and optionally suppresses leading zeros. It sits between the core logic producing display values and the board `an`/`seg`/`dp` pins, and replaces free-running anode rotation with slot-timed, segment-synchronous scanning.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `DIGIT_HZ`, 1000, digit slot rate. Slot length `DIV = CLK_HZ/DIGIT_HZ` cycles.
- `BLANK_CYC`, 1000, dead-time cycles at the start of each slot. Elaboration check: `0 < BLANK_CYC < DIV`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `value` in 16: four hex nibbles; `value[3:0]` is the rightmost digit (`an[0]`).
- `dp_in` in 4: decimal point request per digit, active-high; bit i belongs to digit i.
- `lz_en` in 1: leading-zero suppression enable.
- `an` out 4: anode selects, active-low, at most one bit low at a time.
- `seg` out 7: cathodes, active-low, `{g,f,e,d,c,b,a}`.
- `dp` out 1: decimal point cathode, active-low.
- `frame_done` out 1: one-cycle pulse at the end of each 4-digit frame.

## Operation
- Slot counter `cnt` runs `0..DIV-1`. Digit index `idx` runs `0..3` and advances when `cnt` wraps from `DIV-1`; `idx` wraps from 3 to 0.
- Phase decode:
  - `cnt < BLANK_CYC` → BLANK: `an=4'b1111`, `seg=7'h7F`, `dp=1`.
  - Otherwise → SHOW: `an` has bit `idx` low; `seg` = hex decode of `shadow[4*idx+:4]`; `dp = ~dp_in_sh[idx]`.
- Shadow registers `shadow` and `dp_in_sh` load `value`/`dp_in` only in the cycle where `idx==0` and `cnt==0`. The value is therefore frame-coherent; mid-frame changes to `value` appear in the next frame only.
- Hex decode, active-low: 0→`7'h40`, 1→`7'h79`, 8→`7'h00`, A→`7'h08`, E→`7'h06`, F→`7'h0E`, with standard patterns for all other digits.
- Leading-zero suppression (`lz_en=1`, evaluated on `shadow`): digit i (i=3,2,1) shows `seg=7'h7F` when nibble i and all higher nibbles are 0.
  - `an` is still driven for a suppressed digit, and `dp` still follows `dp_in_sh`.
  - Digit 0 is never suppressed.
- `lz_en` is sampled live, not shadowed.
- `frame_done` pulses when `idx==3` and `cnt==DIV-1`.

## Timing
- All outputs are registered decodes of the current `(idx, cnt)`, giving one cycle of lag.
- Reset values:
  - Outputs: `an=4'b1111`, `seg=7'h7F`, `dp=1`, `frame_done=0`.
  - Internal: `cnt=0`, `idx=0`, `shadow=0`, `dp_in_sh=0`.
- Edge numbering: edge 1 is the first rising edge with `rst=0`.
  - Edge n outputs reflect `cnt=(n-1) mod DIV`.
  - `shadow` captures the `value` present before edge 1.
- With default parameters:
  - `an=4'b1111` for edges 1..1000.
  - `an=4'b1110` for edges 1001..100000.
  - Blank again at edge 100001.
  - `an=4'b1101` from edge 101001.
- `frame_done` is high exactly at edge 400000 and every 400000 edges after that.
- Reset asserted mid-slot: all reset values take effect at the next edge regardless of phase. No partial slot completes.
- `an` never has two bits low. Every transition between digits passes through at least `BLANK_CYC` cycles of `4'b1111`.

## Structure
- Package `seg_pkg` holds:
  - `SEG_OFF = 7'h7F`, `AN_OFF = 4'b1111`.
  - Function `hex_to_seg(logic [3:0]) → logic [6:0]`.
  - Typedef `seg_phase_t {BLANK, SHOW}`.
- Counter width is `$clog2(DIV)`, computed locally.
- One sub-module: `hex_to_seg7` (combinational nibble → active-low segments), instantiated once on the muxed nibble.

## Test plan
Bench parameters: `CLK_HZ=1000`, `DIGIT_HZ=100` (`DIV=10`), `BLANK_CYC=2`.
1. Reset release with `value=16'h1A8F` → `an=1111` at edges 1–2. Then `an=1110`/`seg=7'h0E` at edges 3–10, `1101`/`7'h00` at 13–20, `1011`/`7'h08` at 23–30, `0111`/`7'h79` at 33–40. `frame_done` is high only at edge 40.
2. `value` changes to `16'h0000` at edge 15 → remainder of the frame still shows `1A8F`. Next frame shows `0` on all digits (`seg=7'h40`) with `lz_en=0`.
3. `lz_en=1`, `value=16'h0010` → digits 3 and 2 show `seg=7'h7F` with their anode low. Digit 1 shows `7'h79`, digit 0 shows `7'h40`.
4. `dp_in=4'b0100` → `dp=0` only during the SHOW phase of digit 2. `dp=1` during all BLANK phases.
5. `rst` pulsed at edge 17 (digit 1 SHOW) → next edge `an=1111`, `seg=7'h7F`. Scanning restarts from digit 0 with the blank timing of scenario 1.
6. Assertion over 1000 cycles of random `value`/`dp_in`/`lz_en` → `an` always one-hot-low or `1111`, and every anode change passes through ≥2 cycles of `1111`.
